// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply / 32/32 divide sequencer owning HI/LO.
// Multiply is a 32-step shift-add; divide is a 32-step restoring divide.
// Build option: define MULDIV_SIGNED_EN for two's-complement operands
// (magnitudes at capture, sign correction in FIX). Without it the unit is
// purely unsigned. Cycle timing is identical in both builds.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        MULT_control,
  input  logic        DIV_control,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        multStop,
  output logic        divStop,
  output logic        divZero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        dz_pend;

  // Working registers: acc holds {upper, multiplier} or {remainder, quotient};
  // opnd holds the multiplicand or the divisor.
  logic [63:0] acc;
  logic [31:0] opnd;

  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic [32:0] mul_sum;
  logic [63:0] div_sh;
  logic [32:0] div_top;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_res;
  logic neg_rem;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (32'd0 - v) : v;
  endfunction

  // Operand magnitudes at capture; 0x80000000 maps to itself as an unsigned magnitude.
  always_comb begin
    cap_a = mag32(A_in);
    cap_b = mag32(B_in);
  end

  // Sign correction: product/quotient negated on differing signs, remainder follows dividend.
  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    if (!is_div) begin
      {res_hi, res_lo} = neg_res ? (64'd0 - acc) : acc;
    end else begin
      res_lo = neg_res ? (32'd0 - acc[31:0])  : acc[31:0];
      res_hi = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    end
  end

  // Result signs recorded alongside the operands at capture.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && (MULT_control || DIV_control)) begin
      neg_res <= A_in[31] ^ B_in[31];
      neg_rem <= A_in[31];
    end
  end
`else
  // Unsigned build: operands used as-is and FIX is a plain copy.
  always_comb begin
    cap_a  = A_in;
    cap_b  = B_in;
    res_hi = acc[63:32];
    res_lo = acc[31:0];
  end
`endif

  // One iteration of each algorithm, computed from the current accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_sh   = {acc[62:0], 1'b0};
    div_top  = {acc[63], div_sh[63:32]};
    div_diff = div_top - {1'b0, opnd};
    div_next = div_diff[32] ? div_sh : {div_diff[31:0], div_sh[31:1], 1'b1};
  end

  // Datapath: operand capture in IDLE, one step per cycle in MUL/DIV.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (MULT_control) begin
          opnd <= cap_a;
          acc  <= {32'd0, cap_b};
        end else if (DIV_control) begin
          opnd <= cap_b;
          acc  <= {32'd0, cap_a};
        end
      end
      S_MUL:   acc <= {mul_sum, acc[31:1]};
      S_DIV:   acc <= div_next;
      default: acc <= acc;
    endcase
  end

  // Sequencer FSM, HI/LO load and the registered status strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      dz_pend  <= 1'b0;
      busy     <= 1'b0;
      multStop <= 1'b0;
      divStop  <= 1'b0;
      divZero  <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      multStop <= 1'b0;
      divStop  <= 1'b0;
      divZero  <= dz_pend;
      dz_pend  <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy drops one cycle after DONE so it covers the strobe cycle.
          busy <= 1'b0;
          if (MULT_control) begin
            state  <= S_MUL;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            is_div <= 1'b0;
          end else if (DIV_control) begin
            if (B_in != 32'd0) begin
              state  <= S_DIV;
              busy   <= 1'b1;
              cnt    <= 5'd0;
              is_div <= 1'b1;
            end else begin
              dz_pend <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          HI    <= res_hi;
          LO    <= res_lo;
          state <= S_DONE;
        end
        S_DONE: begin
          multStop <= ~is_div;
          divStop  <= is_div;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq. Works in either build; expected values
// follow MULDIV_SIGNED_EN when it is defined.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        MULT_control;
  logic        DIV_control;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        multStop;
  logic        divStop;
  logic        divZero;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk          (clk),
    .reset        (reset),
    .MULT_control (MULT_control),
    .DIV_control  (DIV_control),
    .A_in         (A_in),
    .B_in         (B_in),
    .HI           (HI),
    .LO           (LO),
    .busy         (busy),
    .multStop     (multStop),
    .divStop      (divStop),
    .divZero      (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start command so that it is sampled on the next rising edge (E0);
  // returns 1 ns after E0 with the start pulses removed.
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MULT_control = m;
    DIV_control  = d;
    A_in         = a;
    B_in         = b;
    @(posedge clk);
    #1;
    MULT_control = 1'b0;
    DIV_control  = 1'b0;
  endtask

  // Advance n rising edges, returning 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    MULT_control = 1'b0;
    DIV_control  = 1'b0;
    A_in         = 32'd0;
    B_in         = 32'd0;

    // Reset state
    step(3);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {29'd0, multStop, divStop, divZero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Multiply 0xFFFFFFFD * 5 with cycle-accurate strobe checks
    start(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5);
    chk("mul_busy_e0", {31'd0, busy}, 32'd1);
    step(32);
    chk("mul_lo_e32_not_yet", LO, 32'd0);
    step(1);
`ifdef MULDIV_SIGNED_EN
    chk("mul_hi", HI, 32'hFFFF_FFFF);
`else
    chk("mul_hi", HI, 32'h0000_0004);
`endif
    chk("mul_lo", LO, 32'hFFFF_FFF1);
    chk("mul_stop_e33", {31'd0, multStop}, 32'd0);
    step(1);
    chk("mul_stop_e34", {31'd0, multStop}, 32'd1);
    chk("mul_busy_e34", {31'd0, busy}, 32'd1);
    chk("mul_divstop_e34", {31'd0, divStop}, 32'd0);
    step(1);
    chk("mul_stop_e35", {31'd0, multStop}, 32'd0);
    chk("mul_busy_e35", {31'd0, busy}, 32'd0);

    // Divide 0xFFFFFFF9 / 2
    start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("div_busy_e0", {31'd0, busy}, 32'd1);
    step(33);
`ifdef MULDIV_SIGNED_EN
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
`else
    chk("div_lo", LO, 32'h7FFF_FFFC);
    chk("div_hi", HI, 32'h0000_0001);
`endif
    step(1);
    chk("div_stop_e34", {31'd0, divStop}, 32'd1);
    chk("div_multstop_e34", {31'd0, multStop}, 32'd0);
    step(1);
    chk("div_stop_e35", {31'd0, divStop}, 32'd0);

    // Divide by zero: single divZero cycle at E0+1, busy low, HI/LO kept
    start(1'b0, 1'b1, 32'd1234, 32'd0);
    chk("dz_e0_strobe", {31'd0, divZero}, 32'd0);
    chk("dz_e0_busy", {31'd0, busy}, 32'd0);
    step(1);
    chk("dz_e1_strobe", {31'd0, divZero}, 32'd1);
    chk("dz_e1_busy", {31'd0, busy}, 32'd0);
    step(1);
    chk("dz_e2_strobe", {31'd0, divZero}, 32'd0);
`ifdef MULDIV_SIGNED_EN
    chk("dz_lo_kept", LO, 32'hFFFF_FFFD);
    chk("dz_hi_kept", HI, 32'hFFFF_FFFF);
`else
    chk("dz_lo_kept", LO, 32'h7FFF_FFFC);
    chk("dz_hi_kept", HI, 32'h0000_0001);
`endif
    step(40);
    chk("dz_no_divstop", {31'd0, divStop}, 32'd0);

    // Reset mid-multiply at E10
    start(1'b1, 1'b0, 32'd3, 32'd3);
    step(10);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_hi", HI, 32'd0);
    chk("mr_lo", LO, 32'd0);
    step(3);
    @(negedge clk);
    reset = 1'b1;
    step(30);
    chk("mr_no_stop", {31'd0, multStop}, 32'd0);
    chk("mr_lo_after", LO, 32'd0);

    // MULT and DIV together: multiply wins; a second MULT at E5 is ignored
    start(1'b1, 1'b1, 32'd6, 32'd7);
    step(4);
    @(negedge clk);
    MULT_control = 1'b1;
    A_in         = 32'd100;
    B_in         = 32'd100;
    @(posedge clk);
    #1;
    MULT_control = 1'b0;
    chk("both_busy_e5", {31'd0, busy}, 32'd1);
    step(28);
    chk("both_hi", HI, 32'd0);
    chk("both_lo", LO, 32'd42);
    step(1);
    chk("both_multstop", {31'd0, multStop}, 32'd1);
    chk("both_divstop", {31'd0, divStop}, 32'd0);
    step(1);
    chk("both_stop_off", {31'd0, multStop}, 32'd0);
    chk("both_busy_e35", {31'd0, busy}, 32'd0);
    step(40);
    chk("both_lo_stable", LO, 32'd42);
    chk("both_no_late_stop", {30'd0, multStop, divStop}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
